// File: rtl/bus_access_pkg.sv
// Shared definitions for the VIC bus access path: cycle codes from the
// classifier, the decoded access kind and the fixed idle addresses.
package bus_access_pkg;

  // Cycle codes. The first letter gives the phi phase the code belongs to:
  // L = low phase (VIC), H = high phase (CPU side).
  localparam logic [3:0] VIC_LP   = 4'd0;
  localparam logic [3:0] VIC_LPI2 = 4'd1;
  localparam logic [3:0] VIC_LS2  = 4'd2;
  localparam logic [3:0] VIC_LR   = 4'd3;
  localparam logic [3:0] VIC_LG   = 4'd4;
  localparam logic [3:0] VIC_LI   = 4'd5;
  localparam logic [3:0] VIC_HPI1 = 4'd6;
  localparam logic [3:0] VIC_HPI3 = 4'd7;
  localparam logic [3:0] VIC_HS1  = 4'd8;
  localparam logic [3:0] VIC_HS3  = 4'd9;
  localparam logic [3:0] VIC_HRI  = 4'd10;
  localparam logic [3:0] VIC_HRC  = 4'd11;
  localparam logic [3:0] VIC_HRX  = 4'd12;
  localparam logic [3:0] VIC_HGC  = 4'd13;
  localparam logic [3:0] VIC_HGI  = 4'd14;
  localparam logic [3:0] VIC_HI   = 4'd15;

  typedef enum logic [2:0] {
    KIND_IDLE,
    KIND_P,
    KIND_S,
    KIND_R,
    KIND_C,
    KIND_G
  } access_kind_e;

  localparam logic [13:0] ADDR_IDLE     = 14'h3FFF;
  localparam logic [13:0] ADDR_ECM_IDLE = 14'h39FF;
  localparam logic [5:0]  REF_BASE_DEF  = 6'h3F;

endpackage

// File: rtl/bus_access_addr_mux.sv
// Address generation: maps a decoded access kind plus the display/sprite
// state onto the 14-bit VIC address. Purely combinational.
module bus_addr_mux
  import bus_access_pkg::*;
#(
  parameter logic [13:0] IDLE_ADDR = ADDR_IDLE,
  parameter logic [5:0]  REF_BASE  = REF_BASE_DEF
) (
  input  access_kind_e kind,
  input  logic [3:0]   vm,
  input  logic [2:0]   cb,
  input  logic [9:0]   vc,
  input  logic [2:0]   rc,
  input  logic         ecm,
  input  logic         bmm,
  input  logic         gfx_idle,
  input  logic [2:0]   sprite_cnt,
  input  logic [7:0]   sprite_ptr,
  input  logic [5:0]   sprite_mc,
  input  logic [7:0]   char_code,
  input  logic [7:0]   ref_cnt,
  output logic [13:0]  addr
);

  // Select the address for the access kind; ECM masks A10..A9 on every g-access.
  always_comb begin
    addr = IDLE_ADDR;
    case (kind)
      KIND_P: addr = {vm, 7'h7F, sprite_cnt};
      KIND_S: addr = {sprite_ptr, sprite_mc};
      KIND_R: addr = {REF_BASE, ref_cnt};
      KIND_C: addr = {vm, vc};
      KIND_G: begin
        if (gfx_idle)
          addr = ecm ? ADDR_ECM_IDLE : ADDR_IDLE;
        else if (bmm)
          addr = {cb[2], vc, rc};
        else
          addr = {cb, char_code, rc};
        if (ecm)
          addr[10:9] = 2'b00;
      end
      default: addr = IDLE_ADDR;
    endcase
  end

endmodule

// File: rtl/bus_access.sv
// VIC bus access consumer: decodes the classifier's cycle code on the
// address strobe, drives addr/aec one clock later, and latches the returned
// data into typed holding registers on the data strobe. Also owns the
// refresh counter and the video matrix line index.
module bus_access
  import bus_access_pkg::*;
#(
  parameter logic [13:0] IDLE_ADDR = ADDR_IDLE,
  parameter logic [5:0]  REF_BASE  = REF_BASE_DEF
) (
  input  logic        clk_dot4x,
  input  logic        rst,
  input  logic        clk_phi,
  input  logic        phase_addr,
  input  logic        phase_data,
  input  logic [3:0]  cycle_type,
  input  logic [2:0]  sprite_cnt,
  input  logic        badline,
  input  logic [3:0]  vm,
  input  logic [2:0]  cb,
  input  logic [9:0]  vc,
  input  logic [2:0]  rc,
  input  logic        ecm,
  input  logic        bmm,
  input  logic        gfx_idle,
  input  logic [5:0]  sprite_mc,
  input  logic [11:0] cbuf_rdata,
  input  logic        ref_reset,
  input  logic [11:0] dbi,
  output logic [13:0] addr,
  output logic        aec,
  output logic [5:0]  vmli,
  output logic        cbuf_we,
  output logic [11:0] char_latch,
  output logic [7:0]  pixel_latch,
  output logic [7:0]  sprite_ptr,
  output logic [7:0]  sprite_byte,
  output logic [1:0]  sprite_byte_idx,
  output logic        sprite_we,
  output logic [7:0]  ref_cnt
);

  access_kind_e kind_q;
  access_kind_e dec_kind;
  logic [1:0]   s_idx_q;
  logic [1:0]   dec_idx;
  logic         dec_aec;
  logic [13:0]  mux_addr;
  logic         fetch_start;

  // Colour nibble of the line-buffer entry is not needed for addressing.
  wire unused_cbuf_colour = ^cbuf_rdata[11:8];

  // Decode the cycle code into an access kind, sprite byte index and bus ownership.
  always_comb begin
    dec_kind = KIND_IDLE;
    dec_idx  = 2'd0;
    dec_aec  = 1'b0;
    case (cycle_type)
      VIC_LP:  begin dec_kind = KIND_P; dec_aec = 1'b1; end
      VIC_HS1: begin dec_kind = KIND_S; dec_idx = 2'd0; dec_aec = 1'b1; end
      VIC_LS2: begin dec_kind = KIND_S; dec_idx = 2'd1; dec_aec = 1'b1; end
      VIC_HS3: begin dec_kind = KIND_S; dec_idx = 2'd2; dec_aec = 1'b1; end
      VIC_LR:  begin dec_kind = KIND_R; dec_aec = 1'b1; end
      VIC_LG:  begin dec_kind = KIND_G; dec_aec = 1'b1; end
      // Without a badline these degrade to the HRX/HGI idle high phase.
      VIC_HRC, VIC_HGC: begin
        if (badline) begin
          dec_kind = KIND_C;
          dec_aec  = 1'b1;
        end
      end
      VIC_HPI1, VIC_HPI3, VIC_HRI, VIC_HRX, VIC_HGI, VIC_HI: dec_aec = 1'b0;
      VIC_LPI2, VIC_LI: dec_aec = 1'b1;
      // Unknown code: the VIC keeps the bus only in its own (low) phase.
      default: dec_aec = ~clk_phi;
    endcase
  end

  assign fetch_start = (cycle_type == VIC_HRC) || (cycle_type == VIC_HRX);

  bus_addr_mux #(
    .IDLE_ADDR (IDLE_ADDR),
    .REF_BASE  (REF_BASE)
  ) u_addr_mux (
    .kind       (dec_kind),
    .vm         (vm),
    .cb         (cb),
    .vc         (vc),
    .rc         (rc),
    .ecm        (ecm),
    .bmm        (bmm),
    .gfx_idle   (gfx_idle),
    .sprite_cnt (sprite_cnt),
    .sprite_ptr (sprite_ptr),
    .sprite_mc  (sprite_mc),
    .char_code  (cbuf_rdata[7:0]),
    .ref_cnt    (ref_cnt),
    .addr       (mux_addr)
  );

  // Access kind register: holds the pending access until its data strobe.
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      kind_q  <= KIND_IDLE;
      s_idx_q <= 2'd0;
    end else if (phase_addr) begin
      kind_q  <= dec_kind;
      s_idx_q <= dec_idx;
    end
  end

  // Address and AEC output registers, loaded on the address strobe.
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      addr <= IDLE_ADDR;
      aec  <= 1'b0;
    end else if (phase_addr) begin
      addr <= mux_addr;
      aec  <= dec_aec;
    end
  end

  // Data holding registers and write strobes, keyed on the pending kind.
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      char_latch      <= 12'h000;
      pixel_latch     <= 8'h00;
      sprite_ptr      <= 8'h00;
      sprite_byte     <= 8'h00;
      sprite_byte_idx <= 2'd0;
      cbuf_we         <= 1'b0;
      sprite_we       <= 1'b0;
    end else begin
      cbuf_we   <= 1'b0;
      sprite_we <= 1'b0;
      if (phase_data) begin
        case (kind_q)
          KIND_P: sprite_ptr <= dbi[7:0];
          KIND_S: begin
            sprite_byte     <= dbi[7:0];
            sprite_byte_idx <= s_idx_q;
            sprite_we       <= 1'b1;
          end
          KIND_C: begin
            char_latch <= dbi;
            cbuf_we    <= 1'b1;
          end
          KIND_G: pixel_latch <= dbi[7:0];
          default: ;
        endcase
      end
    end
  end

  // Line-buffer index: cleared at the start of the fetch window, advanced after each g-access.
  always_ff @(posedge clk_dot4x) begin
    if (rst)
      vmli <= 6'd0;
    else if (phase_addr && fetch_start)
      vmli <= 6'd0;
    else if (phase_data && (kind_q == KIND_G))
      vmli <= vmli + 6'd1;
  end

  // Refresh counter: counts down per r-access, reload takes priority.
  always_ff @(posedge clk_dot4x) begin
    if (rst)
      ref_cnt <= 8'hFF;
    else if (ref_reset)
      ref_cnt <= 8'hFF;
    else if (phase_data && (kind_q == KIND_R))
      ref_cnt <= ref_cnt - 8'd1;
  end

endmodule

// File: tb/tb_bus_access.sv
// Directed bench for bus_access with a queue-based scoreboard: stimulus
// pushes expected address/aec, char-buffer writes and sprite writes, and a
// monitor pops and compares whenever the DUT presents them.
module tb_bus_access;
  import bus_access_pkg::*;

  logic        clk_dot4x = 1'b0;
  logic        rst, clk_phi, phase_addr, phase_data;
  logic [3:0]  cycle_type;
  logic [2:0]  sprite_cnt;
  logic        badline;
  logic [3:0]  vm;
  logic [2:0]  cb;
  logic [9:0]  vc;
  logic [2:0]  rc;
  logic        ecm, bmm, gfx_idle;
  logic [5:0]  sprite_mc;
  logic [11:0] cbuf_rdata;
  logic        ref_reset;
  logic [11:0] dbi;
  logic [13:0] addr;
  logic        aec;
  logic [5:0]  vmli;
  logic        cbuf_we;
  logic [11:0] char_latch;
  logic [7:0]  pixel_latch, sprite_ptr, sprite_byte;
  logic [1:0]  sprite_byte_idx;
  logic        sprite_we;
  logic [7:0]  ref_cnt;

  int errors = 0;
  int checks = 0;

  logic [14:0] sb_addr[$];
  logic [17:0] sb_cbuf[$];
  logic [9:0]  sb_spr[$];
  logic        pa_seen = 1'b0;

  bus_access dut (
    .clk_dot4x(clk_dot4x), .rst(rst), .clk_phi(clk_phi),
    .phase_addr(phase_addr), .phase_data(phase_data), .cycle_type(cycle_type),
    .sprite_cnt(sprite_cnt), .badline(badline), .vm(vm), .cb(cb), .vc(vc),
    .rc(rc), .ecm(ecm), .bmm(bmm), .gfx_idle(gfx_idle), .sprite_mc(sprite_mc),
    .cbuf_rdata(cbuf_rdata), .ref_reset(ref_reset), .dbi(dbi),
    .addr(addr), .aec(aec), .vmli(vmli), .cbuf_we(cbuf_we),
    .char_latch(char_latch), .pixel_latch(pixel_latch), .sprite_ptr(sprite_ptr),
    .sprite_byte(sprite_byte), .sprite_byte_idx(sprite_byte_idx),
    .sprite_we(sprite_we), .ref_cnt(ref_cnt)
  );

  always #5 clk_dot4x = ~clk_dot4x;

  always @(posedge clk_dot4x) pa_seen <= phase_addr && !rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every DUT-presented output against the scoreboard queues.
  always @(negedge clk_dot4x) begin : monitor
    logic [14:0] ea;
    logic [17:0] ec;
    logic [9:0]  es;
    if (pa_seen) begin
      if (sb_addr.size() == 0) chk("addr_unexpected", {17'd0, aec, addr}, 32'hDEAD);
      else begin
        ea = sb_addr.pop_front();
        chk("addr_aec", {17'd0, aec, addr}, {17'd0, ea});
      end
    end
    if (cbuf_we) begin
      if (sb_cbuf.size() == 0) chk("cbuf_we_unexpected", {14'd0, vmli, char_latch}, 32'hDEAD);
      else begin
        ec = sb_cbuf.pop_front();
        chk("cbuf_write", {14'd0, vmli, char_latch}, {14'd0, ec});
      end
    end
    if (sprite_we) begin
      if (sb_spr.size() == 0) chk("sprite_we_unexpected", {22'd0, sprite_byte_idx, sprite_byte}, 32'hDEAD);
      else begin
        es = sb_spr.pop_front();
        chk("sprite_write", {22'd0, sprite_byte_idx, sprite_byte}, {22'd0, es});
      end
    end
  end

  // One access: address strobe, then data strobe (optionally with ref_reset).
  task automatic issue(input logic [3:0] ct, input logic [13:0] ea, input logic eaec,
                       input logic [11:0] d, input logic rr);
    @(negedge clk_dot4x);
    cycle_type = ct;
    clk_phi    = ct[3] | (ct >= VIC_HPI1);
    phase_addr = 1'b1;
    sb_addr.push_back({eaec, ea});
    @(negedge clk_dot4x);
    phase_addr = 1'b0;
    phase_data = 1'b1;
    dbi        = d;
    ref_reset  = rr;
    @(negedge clk_dot4x);
    phase_data = 1'b0;
    ref_reset  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clk_phi = 1'b0; phase_addr = 1'b0; phase_data = 1'b0;
    cycle_type = VIC_LI; sprite_cnt = 3'd0; badline = 1'b0; vm = 4'h0; cb = 3'd0;
    vc = 10'd0; rc = 3'd0; ecm = 1'b0; bmm = 1'b0; gfx_idle = 1'b0;
    sprite_mc = 6'd0; cbuf_rdata = 12'h000; ref_reset = 1'b0; dbi = 12'h000;
    repeat (3) @(negedge clk_dot4x);
    chk("reset_addr", {18'd0, addr}, {18'd0, 14'h3FFF});
    chk("reset_aec", {31'd0, aec}, 32'd0);
    chk("reset_ref_cnt", {24'd0, ref_cnt}, 32'hFF);
    chk("reset_vmli", {26'd0, vmli}, 32'd0);
    chk("reset_latches", {char_latch, pixel_latch, sprite_ptr, sprite_byte_idx, 2'b00}, 32'd0);
    rst = 1'b0;

    // Sprite pointer fetch
    sprite_cnt = 3'd5; vm = 4'h1;
    issue(VIC_LP, 14'h07FD, 1'b1, 12'h0A5, 1'b0);
    chk("sprite_ptr_a5", {24'd0, sprite_ptr}, 32'hA5);
    issue(VIC_LP, 14'h07FD, 1'b1, 12'h080, 1'b0);
    chk("sprite_ptr_80", {24'd0, sprite_ptr}, 32'h80);

    // Sprite data fetches
    sprite_mc = 6'h03;
    sb_spr.push_back({2'd0, 8'h11});
    issue(VIC_HS1, 14'h2003, 1'b1, 12'h011, 1'b0);
    sb_spr.push_back({2'd1, 8'h22});
    issue(VIC_LS2, 14'h2003, 1'b1, 12'h022, 1'b0);
    sb_spr.push_back({2'd2, 8'h33});
    issue(VIC_HS3, 14'h2003, 1'b1, 12'h033, 1'b0);

    // Refresh: five decrements from reset
    for (int i = 0; i < 5; i++)
      issue(VIC_LR, 14'h3FFF - 14'(i), 1'b1, 12'h000, 1'b0);
    chk("ref_cnt_fa", {24'd0, ref_cnt}, 32'hFA);
    @(negedge clk_dot4x); ref_reset = 1'b1;
    @(negedge clk_dot4x); ref_reset = 1'b0;
    chk("ref_reset_ff", {24'd0, ref_cnt}, 32'hFF);
    for (int i = 0; i < 5; i++)
      issue(VIC_LR, 14'h3FFF - 14'(i), 1'b1, 12'h000, (i == 4));
    chk("ref_reset_wins", {24'd0, ref_cnt}, 32'hFF);

    // Idle codes: high phase releases the bus, low phase keeps it
    issue(VIC_HI, 14'h3FFF, 1'b0, 12'h0EE, 1'b0);
    issue(VIC_LI, 14'h3FFF, 1'b1, 12'h0EE, 1'b0);

    // Graphics addressing modes
    bmm = 1'b0; cb = 3'b010; cbuf_rdata = 12'hF41; rc = 3'd3; ecm = 1'b0; gfx_idle = 1'b0;
    issue(VIC_LG, 14'h120B, 1'b1, 12'h0C3, 1'b0);
    chk("pixel_latch_c3", {24'd0, pixel_latch}, 32'hC3);
    ecm = 1'b1;
    issue(VIC_LG, 14'h100B, 1'b1, 12'h0C4, 1'b0);
    gfx_idle = 1'b1;
    issue(VIC_LG, 14'h39FF, 1'b1, 12'h0C5, 1'b0);
    chk("vmli_after_3g", {26'd0, vmli}, 32'd3);
    ecm = 1'b0; gfx_idle = 1'b0;

    // Badline: c-access opens the window, then alternating g/c accesses
    vm = 4'h0; cb = 3'd0; rc = 3'd0; bmm = 1'b1; badline = 1'b1; vc = 10'd0;
    sb_cbuf.push_back({6'd0, 12'h100});
    issue(VIC_HRC, 14'h0000, 1'b1, 12'h100, 1'b0);
    chk("vmli_cleared", {26'd0, vmli}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      vc = 10'(i);
      issue(VIC_LG, 14'(i) << 3, 1'b1, 12'h0FF, 1'b0);
      if (i < 39) begin
        vc = 10'(i + 1);
        sb_cbuf.push_back({6'(i + 1), 12'(12'h100 + i + 1)});
        issue(VIC_HGC, 14'(i + 1), 1'b1, 12'(12'h100 + i + 1), 1'b0);
      end
    end
    chk("vmli_final_40", {26'd0, vmli}, 32'd40);
    badline = 1'b0;
    issue(VIC_HGC, 14'h3FFF, 1'b0, 12'h1AA, 1'b0);
    chk("char_latch_no_badline", {20'd0, char_latch}, 32'h127);

    // Reset between address and data of a c-access
    badline = 1'b1; vm = 4'h2; vc = 10'd5;
    @(negedge clk_dot4x);
    cycle_type = VIC_HRC; clk_phi = 1'b1; phase_addr = 1'b1;
    sb_addr.push_back({1'b1, 14'h0805});
    @(negedge clk_dot4x);
    phase_addr = 1'b0; rst = 1'b1; phase_data = 1'b1; dbi = 12'hABC;
    @(negedge clk_dot4x);
    rst = 1'b0;
    @(negedge clk_dot4x);
    phase_data = 1'b0;
    chk("rst_char_latch", {20'd0, char_latch}, 32'd0);
    chk("rst_addr_aec", {17'd0, aec, addr}, {17'd0, 1'b0, 14'h3FFF});
    chk("rst_vmli_ref", {18'd0, vmli, ref_cnt}, {18'd0, 6'd0, 8'hFF});
    chk("rst_sprite", {14'd0, sprite_ptr, sprite_byte, sprite_byte_idx}, 32'd0);

    repeat (3) @(negedge clk_dot4x);
    chk("sb_addr_drained", sb_addr.size(), 32'd0);
    chk("sb_cbuf_drained", sb_cbuf.size(), 32'd0);
    chk("sb_spr_drained", sb_spr.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
